superpixel_draw_arbiter: RTL and testbench
==========================================

Name: superpixel_draw_arbiter

Overview:
- Shares one superpixel drawing engine between NUM_REQ requesters (game logic, text overlay, cursor, ...).
- Accepts draw commands (superpixel x, y, color ID) through per-requester valid/ack handshakes and grants them round-robin.
- Issues one command at a time to the drawer as a single-cycle valid pulse, then waits for the drawer's done pulse before issuing the next.
- Sits between the user logic and the superpixel drawer, which writes the VGA frame RAM.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- SPIXEL_X_WIDTH, 6: superpixel x width.
- SPIXEL_Y_WIDTH, 6: superpixel y width.
- SPIXEL_X_MAX, 6'd63: largest legal superpixel x.
- SPIXEL_Y_MAX, 6'd47: largest legal superpixel y.
- COLOR_ID_WIDTH, 8: color ID width.
- TIMEOUT_CYCLES, 1023: WAIT-state watchdog limit; 0 disables the watchdog.
- TO_CNT_WIDTH, 10: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_vld  in  NUM_REQ  per-requester command valid.
- req_x  in  NUM_REQ*SPIXEL_X_WIDTH  packed; requester i at [i*SPIXEL_X_WIDTH +: SPIXEL_X_WIDTH].
- req_y  in  NUM_REQ*SPIXEL_Y_WIDTH  packed, same layout.
- req_data  in  NUM_REQ*COLOR_ID_WIDTH  packed, same layout.
- req_ack  out  NUM_REQ  one-hot, 1-cycle pulse: command captured.
- req_done  out  NUM_REQ  one-hot, 1-cycle pulse: that requester's command finished or was rejected.
- draw_x  out  SPIXEL_X_WIDTH  to drawer x.
- draw_y  out  SPIXEL_Y_WIDTH  to drawer y.
- draw_data  out  COLOR_ID_WIDTH  to drawer idata.
- draw_vld  out  1  to drawer idata_vld; 1-cycle pulse.
- draw_done  in  1  from drawer odone; 1-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- err  out  1  1-cycle pulse on out-of-range reject or watchdog expiry.
- clr_req  in  1  clear-screen request (see Optional Feature).
- clr_color  in  COLOR_ID_WIDTH  clear color.
- clr_done  out  1  1-cycle pulse when a clear completes.

Behaviour:
- All outputs are registered.
- Reset (any cycle, including mid-draw):
  - All outputs go to 0 and state goes to IDLE.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Watchdog counter clears; any clear sequence is abandoned.
  - The drawer is reset separately by the same rst.
- States: IDLE, WAIT, plus CLR_ISSUE and CLR_WAIT with the macro.
- Requester protocol:
  - The requester holds req_vld and its payload stable until it sees req_ack.
  - Dropping req_vld before ack is legal; nothing is captured.
  - The requester may raise a new req_vld on the cycle after ack.
- IDLE arbitration (at clock edge k):
  - The grant g is the first asserted req_vld searching (last_grant+1) mod NUM_REQ upward with wrap.
  - If the grant's x <= SPIXEL_X_MAX and y <= SPIXEL_Y_MAX:
    - In cycle k+1: draw_x/y/data = payload, draw_vld = 1, req_ack[g] = 1.
    - last_grant <= g; state <= WAIT.
  - If out of range:
    - In cycle k+1: req_ack[g] = 1, err = 1, draw_vld = 0.
    - In cycle k+2: req_done[g] = 1.
    - last_grant <= g; state stays IDLE.
  - No req_vld asserted: stay in IDLE, no outputs.
- draw_x/y/data hold their last issued value until the next issue.
- WAIT:
  - The watchdog counts cycles from draw_vld.
  - On draw_done: req_done[g] = 1 the next cycle; state <= IDLE. Earliest re-issue is 2 cycles after draw_done.
  - If the counter reaches TIMEOUT_CYCLES with no draw_done: err = 1, req_done[g] = 1, state <= IDLE.
  - draw_done and timeout in the same cycle: done wins, no err.
- draw_done received in IDLE is ignored.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...

Optional Feature:
- Macro: SPIXEL_ARB_CLEAR_EN.
- With the macro, clr_req is sampled in IDLE and has priority over all req_vld:
  - clr_color is latched and the sequencer issues every superpixel in row-major order: y = 0..SPIXEL_Y_MAX, x = 0..SPIXEL_X_MAX.
  - Each draw is a draw_vld pulse followed by a wait for draw_done, with the watchdog active.
  - After the final draw_done (x = SPIXEL_X_MAX, y = SPIXEL_Y_MAX), clr_done pulses for 1 cycle and state returns to IDLE.
  - Requesters are not acked during a clear; clr_req during a clear is ignored.
  - Watchdog expiry aborts the clear: err pulses, no clr_done, state returns to IDLE.
  - last_grant is unchanged by a clear.
- Without the macro: clr_req and clr_color are ignored, clr_done is tied to 0, and the CLR states are absent.

Test Plan:
- Single command:
  - Stimulus: req0 x=5, y=3, data=8'hA5; drawer model returns done 100 cycles after draw_vld.
  - Response: ack[0] and draw_vld with 5/3/A5 one cycle after req_vld; req_done[0] one cycle after draw_done; busy low afterwards.
- Round-robin:
  - Stimulus: req0 and req1 held valid for 4 commands each.
  - Response: draw order 0,1,0,1,...; never two draw_vld without an intervening draw_done.
- Out of range:
  - Stimulus: req1 x=6'd63, y=6'd48.
  - Response: ack[1] + err in the same cycle, req_done[1] the next cycle, no draw_vld.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16; drawer never responds.
  - Response: err and req_done[0] after the 16-cycle limit; the next request is issued normally.
- Reset mid-WAIT:
  - Stimulus: rst asserted 10 cycles after draw_vld.
  - Response: all outputs 0 the next cycle; with req0 and req1 both valid after reset, requester 0 is granted first.
- Clear (macro on):
  - Stimulus: clr_req with clr_color=8'h00 while req0 is valid.
  - Response: 3072 draws, first (0,0), last (63,47); clr_done follows the last draw_done; only then does req0 get its ack.

Source files
------------

// File: rtl/superpixel_draw_arbiter_if.sv
// Requester/drawer bundle for superpixel_draw_arbiter.
// The slave modport is the arbiter's view; the master modport is the user/drawer side.
interface superpixel_draw_arbiter_if #(
  parameter int NUM_REQ        = 2,
  parameter int SPIXEL_X_WIDTH = 6,
  parameter int SPIXEL_Y_WIDTH = 6,
  parameter int COLOR_ID_WIDTH = 8
);
  logic [NUM_REQ-1:0]                req_vld;
  logic [NUM_REQ*SPIXEL_X_WIDTH-1:0] req_x;
  logic [NUM_REQ*SPIXEL_Y_WIDTH-1:0] req_y;
  logic [NUM_REQ*COLOR_ID_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ack;
  logic [NUM_REQ-1:0]                req_done;
  logic [SPIXEL_X_WIDTH-1:0]         draw_x;
  logic [SPIXEL_Y_WIDTH-1:0]         draw_y;
  logic [COLOR_ID_WIDTH-1:0]         draw_data;
  logic                              draw_vld;
  logic                              draw_done;
  logic                              busy;
  logic                              err;
  logic                              clr_req;
  logic [COLOR_ID_WIDTH-1:0]         clr_color;
  logic                              clr_done;

  modport slave (
    input  req_vld, req_x, req_y, req_data, draw_done, clr_req, clr_color,
    output req_ack, req_done, draw_x, draw_y, draw_data, draw_vld, busy, err, clr_done
  );

  modport master (
    output req_vld, req_x, req_y, req_data, draw_done, clr_req, clr_color,
    input  req_ack, req_done, draw_x, draw_y, draw_data, draw_vld, busy, err, clr_done
  );
endinterface

// File: rtl/superpixel_draw_arbiter.sv
// Round-robin arbiter sharing one superpixel drawer among NUM_REQ requesters.
// Define SPIXEL_ARB_CLEAR_EN to add the clear-screen sequencer (CLR_ISSUE/CLR_WAIT).
//
// state        | meaning
// ST_IDLE      | arbitrate requesters (or start a clear)
// ST_WAIT      | command issued, waiting for draw_done or watchdog
// ST_CLR_ISSUE | pulse draw_vld for the current clear superpixel
// ST_CLR_WAIT  | waiting for draw_done of a clear superpixel
module superpixel_draw_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int SPIXEL_X_WIDTH = 6,
  parameter int SPIXEL_Y_WIDTH = 6,
  parameter logic [SPIXEL_X_WIDTH-1:0] SPIXEL_X_MAX = 6'd63,
  parameter logic [SPIXEL_Y_WIDTH-1:0] SPIXEL_Y_MAX = 6'd47,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_CNT_WIDTH   = 10
) (
  input logic clk,
  input logic rst,
  superpixel_draw_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [GW-1:0]           LAST_INIT = GW'(NUM_REQ - 1);
  localparam logic [TO_CNT_WIDTH-1:0] TO_LOAD   = TO_CNT_WIDTH'(TIMEOUT_CYCLES);

`ifdef SPIXEL_ARB_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CLR_ISSUE, ST_CLR_WAIT} state_t;
`else
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
`endif

  state_t state_q, state_nxt;

  logic [GW-1:0]             last_grant_q, last_grant_nxt;
  logic [GW-1:0]             cur_grant_q, cur_grant_nxt;
  logic [TO_CNT_WIDTH-1:0]   to_cnt_q, to_cnt_nxt;
  logic [NUM_REQ-1:0]        rej_pend_q, rej_pend_nxt;
  logic [NUM_REQ-1:0]        ack_q, ack_nxt;
  logic [NUM_REQ-1:0]        done_q, done_nxt;
  logic                      vld_q, vld_nxt;
  logic                      err_q, err_nxt;
  logic                      busy_q;
  logic [SPIXEL_X_WIDTH-1:0] dx_q, dx_nxt;
  logic [SPIXEL_Y_WIDTH-1:0] dy_q, dy_nxt;
  logic [COLOR_ID_WIDTH-1:0] dd_q, dd_nxt;

`ifdef SPIXEL_ARB_CLEAR_EN
  logic [SPIXEL_X_WIDTH-1:0] cx_q, cx_nxt;
  logic [SPIXEL_Y_WIDTH-1:0] cy_q, cy_nxt;
  logic [COLOR_ID_WIDTH-1:0] col_q, col_nxt;
  logic                      clr_done_q, clr_done_nxt;
`else
  logic unused_clr;
  assign unused_clr = ^{bus.clr_req, bus.clr_color};
`endif

  logic [NUM_REQ-1:0]        eligible;
  logic                      found;
  logic [GW-1:0]             gnt, idx;
  logic [SPIXEL_X_WIDTH-1:0] gx;
  logic [SPIXEL_Y_WIDTH-1:0] gy;
  logic [COLOR_ID_WIDTH-1:0] gd;
  logic                      in_range;
  logic [NUM_REQ-1:0]        gnt_1h, cur_1h;
  logic                      wd_expire;

  // The acked requester still shows req_vld during the ack cycle; mask it out.
  always_comb begin
    eligible = bus.req_vld & ~ack_q;
    found    = 1'b0;
    gnt      = '0;
    idx      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = GW'((int'(last_grant_q) + off) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign gx        = bus.req_x[int'(gnt)*SPIXEL_X_WIDTH +: SPIXEL_X_WIDTH];
  assign gy        = bus.req_y[int'(gnt)*SPIXEL_Y_WIDTH +: SPIXEL_Y_WIDTH];
  assign gd        = bus.req_data[int'(gnt)*COLOR_ID_WIDTH +: COLOR_ID_WIDTH];
  assign in_range  = (gx <= SPIXEL_X_MAX) && (gy <= SPIXEL_Y_MAX);
  assign gnt_1h    = NUM_REQ'(1) << gnt;
  assign cur_1h    = NUM_REQ'(1) << cur_grant_q;
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_CNT_WIDTH'(1));

  always_comb begin
    state_nxt      = state_q;
    last_grant_nxt = last_grant_q;
    cur_grant_nxt  = cur_grant_q;
    to_cnt_nxt     = to_cnt_q;
    rej_pend_nxt   = '0;
    ack_nxt        = '0;
    done_nxt       = rej_pend_q;
    vld_nxt        = 1'b0;
    err_nxt        = 1'b0;
    dx_nxt         = dx_q;
    dy_nxt         = dy_q;
    dd_nxt         = dd_q;
`ifdef SPIXEL_ARB_CLEAR_EN
    cx_nxt         = cx_q;
    cy_nxt         = cy_q;
    col_nxt        = col_q;
    clr_done_nxt   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef SPIXEL_ARB_CLEAR_EN
        if (bus.clr_req) begin
          cx_nxt    = '0;
          cy_nxt    = '0;
          col_nxt   = bus.clr_color;
          state_nxt = ST_CLR_ISSUE;
        end else
`endif
        if (found) begin
          ack_nxt        = gnt_1h;
          last_grant_nxt = gnt;
          if (in_range) begin
            dx_nxt        = gx;
            dy_nxt        = gy;
            dd_nxt        = gd;
            vld_nxt       = 1'b1;
            cur_grant_nxt = gnt;
            to_cnt_nxt    = TO_LOAD;
            state_nxt     = ST_WAIT;
          end else begin
            err_nxt      = 1'b1;
            rej_pend_nxt = gnt_1h;
          end
        end
      end
      ST_WAIT: begin
        if (bus.draw_done) begin
          done_nxt  = cur_1h;
          state_nxt = ST_IDLE;
        end else if (wd_expire) begin
          err_nxt   = 1'b1;
          done_nxt  = cur_1h;
          state_nxt = ST_IDLE;
        end else if (to_cnt_q != '0) begin
          to_cnt_nxt = to_cnt_q - TO_CNT_WIDTH'(1);
        end
      end
`ifdef SPIXEL_ARB_CLEAR_EN
      ST_CLR_ISSUE: begin
        dx_nxt     = cx_q;
        dy_nxt     = cy_q;
        dd_nxt     = col_q;
        vld_nxt    = 1'b1;
        to_cnt_nxt = TO_LOAD;
        state_nxt  = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        if (bus.draw_done) begin
          if (cx_q == SPIXEL_X_MAX && cy_q == SPIXEL_Y_MAX) begin
            clr_done_nxt = 1'b1;
            state_nxt    = ST_IDLE;
          end else begin
            if (cx_q == SPIXEL_X_MAX) begin
              cx_nxt = '0;
              cy_nxt = cy_q + SPIXEL_Y_WIDTH'(1);
            end else begin
              cx_nxt = cx_q + SPIXEL_X_WIDTH'(1);
            end
            state_nxt = ST_CLR_ISSUE;
          end
        end else if (wd_expire) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (to_cnt_q != '0) begin
          to_cnt_nxt = to_cnt_q - TO_CNT_WIDTH'(1);
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LAST_INIT;
      cur_grant_q  <= '0;
      to_cnt_q     <= '0;
      rej_pend_q   <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      vld_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      dx_q         <= '0;
      dy_q         <= '0;
      dd_q         <= '0;
`ifdef SPIXEL_ARB_CLEAR_EN
      cx_q         <= '0;
      cy_q         <= '0;
      col_q        <= '0;
      clr_done_q   <= 1'b0;
`endif
    end else begin
      last_grant_q <= last_grant_nxt;
      cur_grant_q  <= cur_grant_nxt;
      to_cnt_q     <= to_cnt_nxt;
      rej_pend_q   <= rej_pend_nxt;
      ack_q        <= ack_nxt;
      done_q       <= done_nxt;
      vld_q        <= vld_nxt;
      err_q        <= err_nxt;
      busy_q       <= (state_nxt != ST_IDLE);
      dx_q         <= dx_nxt;
      dy_q         <= dy_nxt;
      dd_q         <= dd_nxt;
`ifdef SPIXEL_ARB_CLEAR_EN
      cx_q         <= cx_nxt;
      cy_q         <= cy_nxt;
      col_q        <= col_nxt;
      clr_done_q   <= clr_done_nxt;
`endif
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.req_done  = done_q;
  assign bus.draw_x    = dx_q;
  assign bus.draw_y    = dy_q;
  assign bus.draw_data = dd_q;
  assign bus.draw_vld  = vld_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
`ifdef SPIXEL_ARB_CLEAR_EN
  assign bus.clr_done  = clr_done_q;
`else
  assign bus.clr_done  = 1'b0;
`endif
endmodule

// File: tb/tb_superpixel_draw_arbiter.sv
// Scoreboard bench for superpixel_draw_arbiter; a second instance with a short
// watchdog covers timeout behaviour. Clear test is built when SPIXEL_ARB_CLEAR_EN is set.
module tb_superpixel_draw_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  superpixel_draw_arbiter_if #(.NUM_REQ(2)) bus ();
  superpixel_draw_arbiter_if #(.NUM_REQ(2)) bus_wd ();

  superpixel_draw_arbiter #(.NUM_REQ(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  superpixel_draw_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16), .TO_CNT_WIDTH(5))
    dut_wd (.clk(clk), .rst(rst), .bus(bus_wd));

  typedef struct {
    logic [1:0] ack;
    logic [5:0] x;
    logic [5:0] y;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   drawer_delay = 3;
  int   dcnt = 0;
  int   draws = 0;
  logic outstanding = 1'b0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {4'd0, bus.req_ack, bus.req_done, bus.draw_vld, bus.err, bus.busy,
            bus.clr_done, bus.draw_x, bus.draw_y, bus.draw_data};
  endfunction

  function automatic exp_t mk(logic [1:0] ack, logic [5:0] x, logic [5:0] y, logic [7:0] d);
    exp_t e;
    e.ack = ack; e.x = x; e.y = y; e.d = d;
    return e;
  endfunction

  // Monitor plus drawer model: done pulses drawer_delay cycles after draw_vld (0 = never).
  always @(negedge clk) begin
    exp_t e;
    bus.draw_done = 1'b0;
    if (rst) begin
      dcnt = 0;
      outstanding = 1'b0;
    end else begin
      if (bus.draw_vld) begin
        check("overlap", {31'd0, outstanding}, 32'd0);
        outstanding = 1'b1;
        draws++;
        if (sb.size() == 0) begin
          check("unexpected_draw", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("draw_xyd", {12'd0, bus.draw_x, bus.draw_y, bus.draw_data}, {12'd0, e.x, e.y, e.d});
          check("draw_ack", {30'd0, bus.req_ack}, {30'd0, e.ack});
        end
        dcnt = drawer_delay;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          bus.draw_done = 1'b1;
          outstanding = 1'b0;
        end
      end
      if (bus.err) outstanding = 1'b0;
    end
  end

  task automatic issue(int id, logic [5:0] x, logic [5:0] y, logic [7:0] d,
                       output int lat, output logic e);
    @(negedge clk);
    bus.req_vld[id] = 1'b1;
    bus.req_x[id*6 +: 6]    = x;
    bus.req_y[id*6 +: 6]    = y;
    bus.req_data[id*8 +: 8] = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.req_ack[id] && lat < 2000);
    e = bus.err;
    bus.req_vld[id] = 1'b0;
  endtask

  task automatic wait_done(int id, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_done[id] && n < 2000);
  endtask

  task automatic rr(int id);
    int lat;
    logic e;
    for (int n = 0; n < 4; n++) issue(id, 6'(id*10 + n), 6'(n), 8'(id*16 + n), lat, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat, lat1, n, base;
    logic e, e1, early;
    bus.req_vld = '0; bus.req_x = '0; bus.req_y = '0; bus.req_data = '0;
    bus.clr_req = 1'b0; bus.clr_color = '0; bus.draw_done = 1'b0;
    bus_wd.req_vld = '0; bus_wd.req_x = '0; bus_wd.req_y = '0; bus_wd.req_data = '0;
    bus_wd.clr_req = 1'b0; bus_wd.clr_color = '0; bus_wd.draw_done = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    rst = 1'b0;

    // single command, drawer answers after 100 cycles
    drawer_delay = 100;
    sb.push_back(mk(2'b01, 6'd5, 6'd3, 8'hA5));
    issue(0, 6'd5, 6'd3, 8'hA5, lat, e);
    check("single_ack_lat", lat, 1);
    check("single_no_err", {31'd0, e}, 32'd0);
    wait_done(0, n);
    check("single_done_lat", n, 101);
    check("single_done_vec", {30'd0, bus.req_done}, 32'd1);
    @(negedge clk);
    check("single_busy_low", {31'd0, bus.busy}, 32'd0);

    // round robin from reset: 0,1,0,1,...
    do_reset();
    drawer_delay = 3;
    for (int i = 0; i < 8; i++)
      sb.push_back(mk(2'(1 << (i % 2)), 6'((i % 2)*10 + i/2), 6'(i/2), 8'((i % 2)*16 + i/2)));
    fork
      rr(0);
      rr(1);
    join
    wait_done(1, n);
    check("rr_sb_empty", sb.size(), 0);

    // boundary in range, then out of range on y
    sb.push_back(mk(2'b10, 6'd63, 6'd47, 8'h3C));
    issue(1, 6'd63, 6'd47, 8'h3C, lat, e);
    check("edge_ack_lat", lat, 1);
    wait_done(1, n);
    issue(1, 6'd63, 6'd48, 8'h11, lat, e);
    check("oor_ack_lat", lat, 1);
    check("oor_err", {31'd0, e}, 32'd1);
    @(negedge clk);
    check("oor_done", {30'd0, bus.req_done}, 32'd2);
    check("oor_err_pulse", {31'd0, bus.err}, 32'd0);
    sb.push_back(mk(2'b01, 6'd1, 6'd2, 8'h44));
    issue(0, 6'd1, 6'd2, 8'h44, lat, e);
    check("after_oor_ack_lat", lat, 1);
    wait_done(0, n);
    check("after_oor_done_lat", n, 4);

    // reset 10 cycles into WAIT
    drawer_delay = 0;
    sb.push_back(mk(2'b01, 6'd7, 6'd9, 8'h3C));
    issue(0, 6'd7, 6'd9, 8'h3C, lat, e);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midwait_reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    drawer_delay = 3;
    sb.push_back(mk(2'b01, 6'd20, 6'd21, 8'h55));
    sb.push_back(mk(2'b10, 6'd30, 6'd31, 8'h66));
    fork
      issue(0, 6'd20, 6'd21, 8'h55, lat, e);
      issue(1, 6'd30, 6'd31, 8'h66, lat1, e1);
    join
    check("post_reset_first_lat", lat, 1);
    wait_done(1, n);
    check("post_reset_sb_empty", sb.size(), 0);

    // watchdog on the short-timeout instance; its drawer never answers
    @(negedge clk);
    bus_wd.req_vld[0] = 1'b1;
    bus_wd.req_x[5:0] = 6'd2; bus_wd.req_y[5:0] = 6'd4; bus_wd.req_data[7:0] = 8'h11;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_wd.req_ack[0] && n < 50);
    check("wd_issue", {29'd0, bus_wd.req_ack, bus_wd.draw_vld}, {29'd0, 2'b01, 1'b1});
    bus_wd.req_vld[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_wd.err && n < 100);
    check("wd_expire_lat", n, 16);
    check("wd_done", {30'd0, bus_wd.req_done}, 32'd1);
    bus_wd.req_vld[0] = 1'b1;
    bus_wd.req_x[5:0] = 6'd1; bus_wd.req_y[5:0] = 6'd1; bus_wd.req_data[7:0] = 8'h22;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_wd.req_ack[0] && n < 50);
    check("wd_reissue", {11'd0, bus_wd.draw_vld, bus_wd.draw_x, bus_wd.draw_y, bus_wd.draw_data},
          {11'd0, 1'b1, 6'd1, 6'd1, 8'h22});
    check("wd_reissue_lat", n, 1);
    bus_wd.req_vld[0] = 1'b0;

`ifdef SPIXEL_ARB_CLEAR_EN
    // clear screen with req0 waiting; color latched at start
    drawer_delay = 1;
    for (int y = 0; y <= 47; y++)
      for (int x = 0; x <= 63; x++) sb.push_back(mk(2'b00, 6'(x), 6'(y), 8'h00));
    sb.push_back(mk(2'b01, 6'd12, 6'd13, 8'h77));
    base = draws;
    @(negedge clk);
    bus.clr_req = 1'b1; bus.clr_color = 8'h00;
    bus.req_vld[0] = 1'b1;
    bus.req_x[5:0] = 6'd12; bus.req_y[5:0] = 6'd13; bus.req_data[7:0] = 8'h77;
    @(negedge clk);
    bus.clr_req = 1'b0; bus.clr_color = 8'hFF;
    early = bus.req_ack[0];
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.req_ack[0]) early = 1'b1;
    end while (!bus.clr_done && n < 40000);
    check("clr_done_seen", {31'd0, bus.clr_done}, 32'd1);
    check("clr_no_early_ack", {31'd0, early}, 32'd0);
    check("clr_draw_count", draws - base, 3072);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ack[0] && n < 20);
    check("clr_then_ack", {31'd0, bus.req_ack[0]}, 32'd1);
    bus.req_vld[0] = 1'b0;
    wait_done(0, n);
    check("clr_sb_empty", sb.size(), 0);
`else
    // clr_req has no effect without the clear feature
    bus.clr_req = 1'b1;
    sb.push_back(mk(2'b01, 6'd12, 6'd13, 8'h77));
    issue(0, 6'd12, 6'd13, 8'h77, lat, e);
    bus.clr_req = 1'b0;
    check("noclr_ack_lat", lat, 1);
    wait_done(0, n);
    check("noclr_clr_done", {31'd0, bus.clr_done}, 32'd0);
    check("noclr_sb_empty", sb.size(), 0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end
endmodule
